// File: rtl/uc_pkg.sv
// Shared types and helpers for the unit clause arbiter: literal encoding,
// variable-space sizes and the arbiter state enum.
package uc_pkg;

    localparam int unsigned DATA_LEN = 512;
    localparam int unsigned LIT_W    = $clog2(DATA_LEN);
    localparam int unsigned NUM_VAR  = DATA_LEN / 2;
    localparam int unsigned VAR_W    = LIT_W - 1;
    localparam int unsigned CNT_W    = $clog2(NUM_VAR) + 1;

    typedef logic [LIT_W-1:0] lit_t;
    typedef logic [VAR_W-1:0] var_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CONFLICT
    } state_t;

    // Literal layout: bit0 = negated, upper bits = variable index.
    function automatic var_t lit_var(input lit_t lit);
        return lit[LIT_W-1:1];
    endfunction

    function automatic logic lit_neg(input lit_t lit);
        return lit[0];
    endfunction

endpackage

// File: rtl/uc_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after its pointer
// and moves the pointer just past the winner whenever a grant is issued.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_nxt;
    logic             found;

    // Scan from the pointer with wraparound; the first hit wins.
    always_comb begin
        grant   = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!found && en && req[PTR_W'((32'(ptr) + k) % N)]) begin
                grant[PTR_W'((32'(ptr) + k) % N)] = 1'b1;
                ptr_nxt = PTR_W'((32'(ptr) + k + 1) % N);
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/uc_arbiter.sv
// Unit clause arbiter: accepts one engine literal per cycle, forwards new
// assignments to the unit clause queue, drops duplicates, flags conflicts.
module uc_arbiter
    import uc_pkg::*;
#(
    parameter int unsigned NUM_ENG = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NUM_ENG-1:0]       eng_uc_valid,
    input  logic [NUM_ENG*LIT_W-1:0] eng_uc_lit,
    output logic [NUM_ENG-1:0]       eng_uc_ready,
    input  logic                     ucq_full,
    output logic                     ucq_push,
    output lit_t                     ucq_data,
    output logic                     conflict,
    output lit_t                     conflict_lit,
    output logic [CNT_W-1:0]         n_assigned
);

    state_t             state;
    logic [NUM_VAR-1:0] asg_map;
    logic [NUM_VAR-1:0] val_map;

    logic [NUM_ENG-1:0] grant;
    lit_t [NUM_ENG:0]   sel_acc;
    lit_t               sel_lit;
    var_t               sel_var;
    logic               sel_neg;
    logic               hit;
    logic               is_asg;
    logic               is_conf;
    logic               arb_en;

    // No grants outside RUN, while the queue is full, or in a start cycle.
    assign arb_en = (state == RUN) && !ucq_full && !start;

    rr_arbiter #(
        .N(NUM_ENG)
    ) u_rr (
        .clk  (clk),
        .rst  (rst),
        .clr  (start),
        .en   (arb_en),
        .req  (eng_uc_valid),
        .grant(grant)
    );

    // One-hot grant selects the winning literal through an OR chain.
    assign sel_acc[0] = '0;
    for (genvar g = 0; g < NUM_ENG; g++) begin : g_sel
        assign sel_acc[g+1] = sel_acc[g] |
                              (grant[g] ? eng_uc_lit[g*LIT_W +: LIT_W] : '0);
    end

    assign sel_lit = sel_acc[NUM_ENG];
    assign sel_var = lit_var(sel_lit);
    assign sel_neg = lit_neg(sel_lit);
    assign hit     = |grant;
    assign is_asg  = asg_map[sel_var];
    assign is_conf = hit && is_asg && (val_map[sel_var] != sel_neg);

    assign eng_uc_ready = grant;
    assign ucq_push     = hit && !is_asg;
    assign ucq_data     = ucq_push ? sel_lit : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            asg_map      <= '0;
            val_map      <= '0;
            n_assigned   <= '0;
            conflict     <= 1'b0;
            conflict_lit <= '0;
        end else if (start) begin
            state        <= RUN;
            asg_map      <= '0;
            val_map      <= '0;
            n_assigned   <= '0;
            conflict     <= 1'b0;
            conflict_lit <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (ucq_push) begin
                        asg_map[sel_var] <= 1'b1;
                        val_map[sel_var] <= sel_neg;
                        if (n_assigned != CNT_W'(NUM_VAR)) begin
                            n_assigned <= n_assigned + CNT_W'(1);
                        end
                    end else if (is_conf) begin
                        conflict     <= 1'b1;
                        conflict_lit <= sel_lit;
                        state        <= CONFLICT;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uc_arbiter.sv
// Self-checking bench for uc_arbiter: directed scenarios plus random traffic,
// compared cycle by cycle against a behavioural assignment-table model.
module tb_uc_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  eng_uc_valid;
    logic [35:0] eng_uc_lit;
    logic [3:0]  eng_uc_ready;
    logic        ucq_full;
    logic        ucq_push;
    logic [8:0]  ucq_data;
    logic        conflict;
    logic [8:0]  conflict_lit;
    logic [8:0]  n_assigned;

    int checks   = 0;
    int failures = 0;

    // Reference model: per-variable value (-1 = unassigned), pointer, flags.
    int         m_val[256];
    int         m_ptr;
    int         m_n;
    bit         m_run;
    bit         m_conf;
    logic [8:0] m_clit;

    always #5 clk = ~clk;

    uc_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .eng_uc_valid(eng_uc_valid),
        .eng_uc_lit  (eng_uc_lit),
        .eng_uc_ready(eng_uc_ready),
        .ucq_full    (ucq_full),
        .ucq_push    (ucq_push),
        .ucq_data    (ucq_data),
        .conflict    (conflict),
        .conflict_lit(conflict_lit),
        .n_assigned  (n_assigned)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_clear();
        foreach (m_val[i]) m_val[i] = -1;
        m_ptr  = 0;
        m_n    = 0;
        m_run  = 1'b0;
        m_conf = 1'b0;
        m_clit = '0;
    endtask

    // One clock: drive inputs, check outputs against the model, advance both.
    task automatic step(input bit r, input bit s, input logic [3:0] v,
                        input logic [8:0] l0, input logic [8:0] l1,
                        input logic [8:0] l2, input logic [8:0] l3,
                        input bit f);
        logic [8:0] la[4];
        logic [8:0] lit;
        logic [3:0] exp_rdy;
        bit         exp_push;
        int         g;
        int         vi;
        int         p;
        la[0] = l0; la[1] = l1; la[2] = l2; la[3] = l3;
        rst = r; start = s; eng_uc_valid = v;
        eng_uc_lit = {l3, l2, l1, l0}; ucq_full = f;
        #2;
        g = -1;
        if (m_run && !m_conf && !s && !f) begin
            for (int k = 0; k < 4; k++) begin
                if (g < 0 && v[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
            end
        end
        lit      = (g >= 0) ? la[g] : 9'h000;
        vi       = int'(lit[8:1]);
        p        = int'(lit[0]);
        exp_rdy  = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        exp_push = (g >= 0) && (m_val[vi] < 0);
        chk("ready", 32'(eng_uc_ready), 32'(exp_rdy));
        chk("push", 32'(ucq_push), 32'(exp_push));
        chk("data", 32'(ucq_data), exp_push ? 32'(lit) : 32'd0);
        chk("conflict", 32'(conflict), 32'(m_conf));
        chk("conflict_lit", 32'(conflict_lit), 32'(m_clit));
        chk("n_assigned", 32'(n_assigned), 32'(m_n));
        @(posedge clk);
        if (r) begin
            m_clear();
        end else if (s) begin
            m_clear();
            m_run = 1'b1;
        end else if (g >= 0) begin
            if (m_val[vi] < 0) begin
                m_val[vi] = p;
                if (m_n < 256) m_n++;
            end else if (m_val[vi] != p) begin
                m_conf = 1'b1;
                m_clit = lit;
            end
            m_ptr = (g + 1) % 4;
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; eng_uc_valid = '0; eng_uc_lit = '0; ucq_full = 1'b0;
        m_clear();
        repeat (2) @(posedge clk);
        #1;

        // Reset state, then a single positive literal.
        step(1, 0, 4'b0000, 0, 0, 0, 0, 0);
        step(0, 1, 4'b0000, 0, 0, 0, 0, 0);
        step(0, 0, 4'b0001, 9'h014, 0, 0, 0, 0);
        step(0, 0, 4'b0000, 0, 0, 0, 0, 0);

        // Round-robin over four distinct literals, then duplicates.
        step(0, 1, 4'b0000, 0, 0, 0, 0, 0);
        repeat (6) step(0, 0, 4'b1111, 9'h002, 9'h004, 9'h006, 9'h008, 0);

        // Same literal from two engines in one cycle.
        repeat (2) step(0, 0, 4'b0110, 0, 9'h021, 9'h021, 0, 0);

        // Assign 0x014 then contradict it; CONFLICT holds until start.
        step(0, 0, 4'b0001, 9'h014, 0, 0, 0, 0);
        repeat (3) step(0, 0, 4'b1000, 0, 0, 0, 9'h015, 0);
        step(0, 1, 4'b0000, 0, 0, 0, 0, 0);
        chk("conflict_cleared", 32'(conflict), 32'd0);
        chk("n_cleared", 32'(n_assigned), 32'd0);

        // Queue full backpressure, then release.
        repeat (3) step(0, 0, 4'b0001, 9'h030, 0, 0, 0, 1);
        step(0, 0, 4'b0001, 9'h030, 0, 0, 0, 0);

        // Reset alongside a live grant, then no grants until start.
        step(1, 0, 4'b0100, 0, 0, 9'h041, 0, 0);
        repeat (2) step(0, 0, 4'b1111, 9'h050, 9'h052, 9'h054, 9'h056, 0);

        // Assign every variable to hit the counter ceiling.
        step(0, 1, 4'b0000, 0, 0, 0, 0, 0);
        for (int i = 0; i < 256; i++) step(0, 0, 4'b0001, 9'(i * 2), 0, 0, 0, 0);
        step(0, 0, 4'b0001, 9'h000, 0, 0, 0, 0);
        chk("n_saturated", 32'(n_assigned), 32'd256);

        // Random traffic over a small variable range to provoke collisions.
        step(0, 1, 4'b0000, 0, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0,
                 4'($urandom), 9'($urandom_range(0, 31)), 9'($urandom_range(0, 31)),
                 9'($urandom_range(0, 31)), 9'($urandom_range(0, 31)),
                 $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uc_arbiter.md
# uc_arbiter

Unit Clause Arbiter: collects unit-literal implications produced by the process engines and pushes each distinct, non-conflicting literal into the unit clause queue. It sits directly upstream of the queue. It picks one engine per cycle by round-robin and tracks the current partial assignment in variable bitmaps, so duplicates are dropped and contradictory implications raise a sticky conflict.

## Interface
- NUM_ENG, 4, number of process engines feeding the arbiter
- DATA_LEN, 512, literal space; LIT_W = $clog2(DATA_LEN) = 9; NUM_VAR = DATA_LEN/2 = 256
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse: clear assignment, begin a new solve
- eng_uc_valid  in  NUM_ENG  engine i offers a unit literal
- eng_uc_lit  in  NUM_ENG×LIT_W  literal per engine; bit0 = polarity (1 = negated), bits[LIT_W-1:1] = variable index
- eng_uc_ready  out  NUM_ENG  one-hot accept; the literal is consumed when valid&ready
- ucq_full  in  1  queue full
- ucq_push  out  1  push strobe to queue
- ucq_data  out  LIT_W  literal pushed
- conflict  out  1  sticky conflict flag
- conflict_lit  out  LIT_W  literal that caused the conflict
- n_assigned  out  $clog2(NUM_VAR)+1  count of variables assigned since start

## Operation
- States: IDLE (reset state; no ready), RUN, CONFLICT (no ready; flags held).
- start in any state: clear assigned/value bitmaps, n_assigned, rr pointer, conflict, conflict_lit; next state RUN. No grant in the start cycle.
- RUN, ucq_full=0: grant the first valid engine at or after the rr pointer (mod NUM_ENG); eng_uc_ready = that one-hot; pointer <= granted+1 mod NUM_ENG. No valid: pointer holds.
- RUN, ucq_full=1: ready all 0, pointer holds.
- Classify the granted literal L (var v, pol p) against the bitmaps:
  - unassigned: ucq_push=1, ucq_data=L, assigned[v]<=1, value[v]<=p, n_assigned+=1.
  - assigned, value==p (duplicate): consumed, no push, no state change.
  - assigned, value!=p: consumed, no push; conflict<=1, conflict_lit<=L, next state CONFLICT.
- CONFLICT exits only on start or rst.
- n_assigned saturates at NUM_VAR, a value it can reach only by assigning every variable.

## Timing
- Reset values: state IDLE, all ready 0, ucq_push 0, ucq_data 0, conflict 0, conflict_lit 0, n_assigned 0, pointer 0, bitmaps 0.
- ucq_push, ucq_data and eng_uc_ready are combinational from the registered state, bitmaps, pointer, eng_uc_* and ucq_full. A push occurs in the same cycle as the handshake, with zero latency.
- Bitmap, counter and pointer updates are visible the cycle after the handshake. At most one literal is accepted per cycle.
- ucq_push is never asserted while ucq_full=1.
- Two engines offering the same literal in one cycle: one is granted and pushed. The other is granted in a later cycle and dropped as a duplicate.
- rst mid-solve: all state returns to reset values on the next edge; rst has priority over start.

## Structure
- Package uc_pkg holds:
  - LIT_W, NUM_VAR
  - lit_t typedef
  - the state enum {IDLE, RUN, CONFLICT}
  - functions lit_var(lit) and lit_neg(lit)
- Sub-module rr_arbiter (parameter N): inputs req[N], en; outputs one-hot grant[N]; holds its own pointer, which advances only when en and a grant occurs.
- Bitmaps are two NUM_VAR-bit flop vectors in uc_arbiter. Clearing is a single-cycle whole-vector reset on start.

## Test plan
- Reset, then start; engine 0 offers lit 0x014 (var 10, positive) -> same-cycle ucq_push=1, ucq_data=0x014; next cycle n_assigned=1.
- All 4 engines valid with distinct literals 0x002/0x004/0x006/0x008 every cycle, ucq_full=0 -> grants in order 0,1,2,3, then wraps to 0; the first four cycles push all four literals, after which re-offered literals are dropped as duplicates.
- Engines 1 and 2 both offer 0x021 in the same cycle -> one push of 0x021; the second is consumed with no push; n_assigned increments once.
- 0x014 already assigned; engine 3 offers 0x015 -> no push, conflict=1, conflict_lit=0x015, ready stays 0 in later cycles; start then clears conflict and n_assigned to 0.
- ucq_full=1 with engine 0 valid for 3 cycles -> ready=0 and ucq_push=0 throughout; full drops -> push on that cycle.
- rst asserted in the same cycle as a valid grant -> the push is still visible combinationally; after the edge all outputs are at reset values and the state is IDLE, so no grants occur until start.
